// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  // The counter must be able to represent WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the signed-overflow result bit.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, borrow_in,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  overflow,
`endif
    input  ready, busy, done, d, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output overflow,
`endif
    output ready, busy, done, d, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - borrow_in, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d          = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock over WIDTH cycles.
// Optional SERIAL_SUB_OVERFLOW_EN: adds a signed-overflow output held with d.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             borrow_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cell_d;
  logic             cell_borrow;
  logic             accept;
  logic             last_bit;

  full_subtractor_cell u_cell (
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .borrow_in  (borrow_q),
    .d          (cell_d),
    .borrow_out (cell_borrow)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = (cnt_q == CNT_LAST);
    res_next = {cell_d, res_sh};
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic overflow_q;
`endif

  // The result register only needs WIDTH-1 bits: the final bit comes straight from the cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      d_q          <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh     <= bus.a;
        b_sh     <= bus.b;
        borrow_q <= bus.borrow_in;
        res_sh   <= '0;
        cnt_q    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_q  <= bus.a[WIDTH-1];
        b_msb_q  <= bus.b[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
        a_sh     <= a_sh >> 1;
        b_sh     <= b_sh >> 1;
        borrow_q <= cell_borrow;
        res_sh   <= res_next[WIDTH-1:1];
        if (last_bit) begin
          cnt_q        <= '0;
          d_q          <= res_next;
          borrow_out_q <= cell_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
          overflow_q   <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.ready      = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.d          = d_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    int               accept_cycle;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cycle_cnt;
  logic prev_done;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      check_output("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cycle_cnt);
      end else begin
        e = sb.pop_front();
        check_output("d", {24'd0, bus.d}, {24'd0, e.d});
        check_output("borrow_out", {31'd0, bus.borrow_out}, {31'd0, e.bo});
        check_output("latency", cycle_cnt - e.accept_cycle, WIDTH);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check_output("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
`endif
      end
    end
    prev_done = bus.done;
  end

  // Issues one start pulse at a negedge; returns at the negedge after the accepting edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bi, input bit push,
                                input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                                input logic exp_ov);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.borrow_in = bi;
    if (push) begin
      e.d            = exp_d;
      e.bo           = exp_bo;
      e.ov           = exp_ov;
      e.accept_cycle = cycle_cnt + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = 8'hA5;
    bus.b         = 8'h5A;
    bus.borrow_in = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 pending results", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_reset_state(input string tag);
    check_output({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_output({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_output({tag, "_d"}, {24'd0, bus.d}, 32'd0);
    check_output({tag, "_borrow_out"}, {31'd0, bus.borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check_output({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    checks        = 0;
    failures      = 0;
    cycle_cnt     = 0;
    prev_done     = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset_state("reset");
    reset = 1'b0;

    // Basic operations; busy/ready checked just after the first accept.
    apply_stimulus(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    check_output("busy_in_run", {31'd0, bus.busy}, 32'd1);
    check_output("ready_in_run", {31'd0, bus.ready}, 32'd0);
    wait_drain();
    @(negedge clk);
    check_output("d_held", {24'd0, bus.d}, 32'h02);
    check_output("ready_after_done", {31'd0, bus.ready}, 32'd1);

    apply_stimulus(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_drain();
    apply_stimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    wait_drain();
    apply_stimulus(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    wait_drain();

    // A start pulse mid-run must not disturb the operation in flight.
    apply_stimulus(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.a          = 8'h40;
    bus.b          = 8'h10;
    bus.borrow_in  = 1'b0;
    e.d            = 8'h30;
    e.bo           = 1'b0;
    e.ov           = 1'b0;
    e.accept_cycle = cycle_cnt + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.a = 8'h20;
    bus.b = 8'h30;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("b2b_first_done_seen", {31'd0, bus.done}, 32'd1);
    e.d            = 8'hF0;
    e.bo           = 1'b1;
    e.ov           = 1'b0;
    e.accept_cycle = cycle_cnt + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check_output("b2b_no_idle", {31'd0, bus.busy}, 32'd1);
    wait_drain();

    // Reset mid-run discards the partial result and produces no done.
    apply_stimulus(8'h55, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_reset_state("abort");
    reset = 1'b0;
    repeat (12) @(negedge clk);

    apply_stimulus(8'h9A, 8'h4B, 1'b1, 1'b1, 8'h4E, 1'b0, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
